// File: rtl/bsg_age_sched.sv
// bsg_age_sched: age-ordered request scheduler with a one-entry
// registered grant and valid/ready handoff downstream.
//
// Parameters:
//   inputs_p    number of requesters (2..16)
//   age_width_p width of each saturating age counter (2..8)
// Ports:
//   clk_i      clock, rising edge
//   reset_i    async active-high reset
//   v_i        per-requester valid, held until yumi_o
//   yumi_o     one-hot consume strobe (combinational)
//   v_o        a grant is presented downstream
//   grants_o   registered one-hot grant
//   sel_id_o   binary index of grants_o
//   ready_i    downstream accepts the presented grant
//   starve_o   a pending requester has a saturated age
// Optional feature macro: BSG_AGE_SCHED_STARVE_ALARM_EN
//   defined   -> starve_o is a registered saturation alarm
//   undefined -> starve_o is tied low
module bsg_age_sched #(
  parameter int inputs_p    = 4,
  parameter int age_width_p = 4,
  localparam int sel_w_lp   = $clog2(inputs_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [inputs_p-1:0] v_i,
  output logic [inputs_p-1:0] yumi_o,
  output logic                v_o,
  output logic [inputs_p-1:0] grants_o,
  output logic [sel_w_lp-1:0] sel_id_o,
  input  logic                ready_i,
  output logic                starve_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                 r_state;
  logic                   r_v;
  logic [inputs_p-1:0]    r_grants;
  logic [sel_w_lp-1:0]    r_sel;
  logic [age_width_p-1:0] r_age [inputs_p];

  logic [inputs_p-1:0]    w_yumi;
  logic [inputs_p-1:0]    w_cand;
  logic [inputs_p-1:0]    w_win;
  logic [sel_w_lp-1:0]    w_win_id;
  logic [age_width_p-1:0] w_best;
  logic                   w_found;

  // A grant is consumed only while its requester still holds v_i;
  // an illegally dropped request keeps its grant instead.
  always_comb begin
    w_yumi = '0;
    if (r_state == ST_BUSY && ready_i)
      w_yumi = r_grants & v_i;
  end

  // Oldest contender wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_cand   = (r_state == ST_BUSY) ? (v_i & ~w_yumi) : v_i;
    w_found  = 1'b0;
    w_best   = '0;
    w_win_id = '0;
    w_win    = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (w_cand[i] && (!w_found || r_age[i] > w_best)) begin
        w_found  = 1'b1;
        w_best   = r_age[i];
        w_win_id = sel_w_lp'(i);
      end
    end
    if (w_found)
      w_win[w_win_id] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_v      <= 1'b0;
      r_grants <= '0;
      r_sel    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_BUSY;
            r_v      <= 1'b1;
            r_grants <= w_win;
            r_sel    <= w_win_id;
          end
        end
        ST_BUSY: begin
          if (|w_yumi) begin
            if (w_found) begin
              r_grants <= w_win;
              r_sel    <= w_win_id;
            end else begin
              r_state  <= ST_IDLE;
              r_v      <= 1'b0;
              r_grants <= '0;
              r_sel    <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ages clear when idle or consumed and saturate at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < inputs_p; i++)
        r_age[i] <= '0;
    end else begin
      for (int i = 0; i < inputs_p; i++) begin
        if (!v_i[i] || w_yumi[i])
          r_age[i] <= '0;
        else if (r_age[i] != '1)
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

`ifdef BSG_AGE_SCHED_STARVE_ALARM_EN
  logic [inputs_p-1:0] w_sat;
  logic                r_starve;

  always_comb begin
    w_sat = '0;
    for (int i = 0; i < inputs_p; i++)
      w_sat[i] = v_i[i] && (r_age[i] == '1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_starve <= 1'b0;
    else
      r_starve <= |w_sat;
  end

  assign starve_o = r_starve;
`else
  assign starve_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && r_state == ST_BUSY &&
        (r_grants & v_i) == '0)
      $display("ERROR: bsg_age_sched granted request dropped");
  end
`endif

  assign yumi_o   = w_yumi;
  assign v_o      = r_v;
  assign grants_o = r_grants;
  assign sel_id_o = r_sel;

endmodule

// File: tb/tb_bsg_age_sched.sv
// tb_bsg_age_sched: directed vector table plus hand sequences
// for age ordering, saturation and asynchronous reset.
module tb_bsg_age_sched;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] v_i;
  logic [3:0] yumi_o;
  logic       v_o;
  logic [3:0] grants_o;
  logic [1:0] sel_id_o;
  logic       ready_i;
  logic       starve_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_age_sched #(
    .inputs_p(4),
    .age_width_p(2)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(v_i),
    .yumi_o(yumi_o),
    .v_o(v_o),
    .grants_o(grants_o),
    .sel_id_o(sel_id_o),
    .ready_i(ready_i),
    .starve_o(starve_o)
  );

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic       ev;
    logic [3:0] eg;
    logic [1:0] es;
    logic [3:0] ey;
  } vec_t;

  vec_t tbl [15];

`ifdef BSG_AGE_SCHED_STARVE_ALARM_EN
  localparam logic STARVE_EXP = 1'b1;
`else
  localparam logic STARVE_EXP = 1'b0;
`endif

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v,
                       input logic rdy);
    @(negedge clk_i);
    v_i     = v;
    ready_i = rdy;
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic ev,
                         input logic [3:0] eg,
                         input logic [1:0] es,
                         input logic [3:0] ey);
    chk({tag, ".v_o"}, 8'(v_o), 8'(ev));
    chk({tag, ".grants"}, 8'(grants_o), 8'(eg));
    chk({tag, ".sel"}, 8'(sel_id_o), 8'(es));
    chk({tag, ".yumi"}, 8'(yumi_o), 8'(ey));
  endtask

  initial begin
    // Single request, simultaneous tie, back-to-back drain.
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000};
    tbl[2]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000};
    tbl[4]  = '{4'b1010, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000};
    tbl[5]  = '{4'b1010, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0000};
    tbl[6]  = '{4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010};
    tbl[7]  = '{4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000};
    tbl[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000};
    tbl[10] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001};
    tbl[11] = '{4'b1110, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010};
    tbl[12] = '{4'b1100, 1'b1, 1'b1, 4'b0100, 2'd2, 4'b0100};
    tbl[13] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000};

    reset_i = 1'b1;
    v_i     = 4'b0000;
    ready_i = 1'b0;
    #2;
    chk_out("in_reset", 1'b0, 4'b0000, 2'd0, 4'b0000);
    chk("in_reset.starve", 8'(starve_o), 8'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].ev,
              tbl[i].eg, tbl[i].es, tbl[i].ey);
    end

    // Age ordering: requester 3 waits longer than requester 0.
    drive(4'b0010, 1'b0);
    drive(4'b1010, 1'b0);
    chk_out("age.busy", 1'b1, 4'b0010, 2'd1, 4'b0000);
    drive(4'b1010, 1'b0);
    drive(4'b1011, 1'b0);
    drive(4'b1011, 1'b0);
    chk_out("age.hold", 1'b1, 4'b0010, 2'd1, 4'b0000);
    drive(4'b1011, 1'b1);
    chk_out("age.cons", 1'b1, 4'b0010, 2'd1, 4'b0010);
    drive(4'b1001, 1'b1);
    chk_out("age.old", 1'b1, 4'b1000, 2'd3, 4'b1000);
    drive(4'b0001, 1'b1);
    chk_out("age.young", 1'b1, 4'b0001, 2'd0, 4'b0001);
    drive(4'b0000, 1'b0);
    chk_out("age.idle", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // Saturation: req3 waits 10 edges, req0 only 2.
    // A wrapping counter would give 2 vs 2 and grant req0.
    drive(4'b0010, 1'b0);
    for (int k = 0; k < 8; k++)
      drive(4'b1010, 1'b0);
    drive(4'b1011, 1'b0);
    drive(4'b1011, 1'b0);
    drive(4'b1011, 1'b1);
    chk_out("sat.cons", 1'b1, 4'b0010, 2'd1, 4'b0010);
    chk("sat.starve", 8'(starve_o), 8'(STARVE_EXP));
    drive(4'b1001, 1'b0);
    chk_out("sat.nowrap", 1'b1, 4'b1000, 2'd3, 4'b0000);

    // Asynchronous reset between edges while busy.
    #2;
    reset_i = 1'b1;
    #1;
    chk_out("areset", 1'b0, 4'b0000, 2'd0, 4'b0000);
    chk("areset.starve", 8'(starve_o), 8'd0);
    drive(4'b0000, 1'b0);
    reset_i = 1'b0;
    #1;
    chk_out("post_rst", 1'b0, 4'b0000, 2'd0, 4'b0000);
    drive(4'b0100, 1'b1);
    chk_out("post_rst.idle", 1'b0, 4'b0000, 2'd0, 4'b0000);
    drive(4'b0100, 1'b1);
    chk_out("post_rst.grant", 1'b1, 4'b0100, 2'd2, 4'b0100);
    drive(4'b0000, 1'b0);
    chk_out("post_rst.done", 1'b0, 4'b0000, 2'd0, 4'b0000);
    chk("end.starve", 8'(starve_o), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
